ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX/MEM pipeline stage for the MIPS datapath. Registers EX results (pcAdded, zeroFlag,

---
 rtl/ex_mem_pipe_stage.sv | 137 +++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional EXMEM_BRANCH_RESOLVE_EN adds a registered out_taken branch decision.
module ex_mem_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc_added,
  input  logic                  zero_flag,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic [CTRL_W-1:0]     ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pc_added,
  output logic                  out_zero_flag,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_write_data,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
`ifdef EXMEM_BRANCH_RESOLVE_EN
  output logic                  out_taken,
`endif
  output logic [CTRL_W-1:0]     out_ctrl
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic                  zero;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     wd;
    logic [REG_ADDR_W-1:0] rd;
    logic [CTRL_W-1:0]     ctrl;
  } entry_t;

  entry_t in_e;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   accept, advance;

  assign in_e = '{
    pc:   pc_added,
    zero: zero_flag,
    alu:  alu_result,
    wd:   write_data,
    rd:   dest_reg,
    ctrl: ctrl
  };

  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & ~skid_v_q;
  assign advance  = main_v_q & out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      unique case (1'b1)
        ~main_v_q: begin
          if (accept) begin
            main_d   = in_e;
            main_v_d = 1'b1;
          end
        end
        main_v_q & ~skid_v_q: begin
          if (accept & advance) begin
            main_d = in_e;
          end else if (accept) begin
            skid_d   = in_e;
            skid_v_d = 1'b1;
          end else if (advance) begin
            main_v_d = 1'b0;
          end
        end
        main_v_q & skid_v_q: begin
          if (advance) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Bubbles must never carry live control into MEM/WB.
  assign out_valid      = main_v_q;
  assign out_ctrl       = main_v_q ? main_q.ctrl : '0;
  assign out_pc_added   = main_q.pc;
  assign out_zero_flag  = main_q.zero;
  assign out_alu_result = main_q.alu;
  assign out_write_data = main_q.wd;
  assign out_dest_reg   = main_q.rd;

`ifdef EXMEM_BRANCH_RESOLVE_EN
  logic taken_q, taken_d;

  assign taken_d = main_v_d &
    ((main_d.ctrl[0] & main_d.zero) | main_d.ctrl[5]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taken_q <= 1'b0;
    else        taken_q <= taken_d;
  end

  assign out_taken = taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed self-checking bench for ex_mem_pipe_stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ex_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_added;
  logic        zero_flag;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  dest_reg;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_added;
  logic        out_zero_flag;
  logic [31:0] out_alu_result;
  logic [31:0] out_write_data;
  logic [4:0]  out_dest_reg;
  logic [5:0]  out_ctrl;
`ifdef EXMEM_BRANCH_RESOLVE_EN
  logic        out_taken;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc_added       (pc_added),
    .zero_flag      (zero_flag),
    .alu_result     (alu_result),
    .write_data     (write_data),
    .dest_reg       (dest_reg),
    .ctrl           (ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc_added   (out_pc_added),
    .out_zero_flag  (out_zero_flag),
    .out_alu_result (out_alu_result),
    .out_write_data (out_write_data),
    .out_dest_reg   (out_dest_reg),
`ifdef EXMEM_BRANCH_RESOLVE_EN
    .out_taken      (out_taken),
`endif
    .out_ctrl       (out_ctrl)
  );

  task automatic drive(input logic v, input logic [31:0] tag,
                       input logic [5:0] c, input logic z);
    in_valid   = v;
    alu_result = tag;
    pc_added   = tag + 32'h4;
    write_data = ~tag;
    dest_reg   = tag[4:0];
    ctrl       = c;
    zero_flag  = z;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 6'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_ctrl !== 6'b0 || out_alu_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs ctrl=%b alu=%h exp=0", out_ctrl, out_alu_result);
    end
`ifdef EXMEM_BRANCH_RESOLVE_EN
    checks++;
    if (out_taken !== 1'b0) begin
      errors++; $display("FAIL reset_taken got=%b exp=0", out_taken);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 6'b001000, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'h10 ||
        out_ctrl !== 6'b001000) begin
      errors++;
      $display("FAIL pass_main v=%b alu=%h ctrl=%b exp 1/10/001000",
               out_valid, out_alu_result, out_ctrl);
    end
    checks++;
    if (out_pc_added !== 32'h14 || out_write_data !== 32'hFFFF_FFEF ||
        out_dest_reg !== 5'h10 || out_zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL pass_fields pc=%h wd=%h rd=%h z=%b exp 14/ffffffef/10/1",
               out_pc_added, out_write_data, out_dest_reg, out_zero_flag);
    end
    drive(1'b0, 32'h0, 6'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'b0) begin
      errors++;
      $display("FAIL pass_drain v=%b ctrl=%b exp 0/0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 6'b001000, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'hA || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_A v=%b alu=%h rdy=%b exp 1/a/1",
               out_valid, out_alu_result, in_ready);
    end
    drive(1'b1, 32'hB, 6'b001000, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      errors++;
      $display("FAIL bp_full rdy=%b alu=%h exp 0/a", in_ready, out_alu_result);
    end
    drive(1'b1, 32'hC, 6'b001000, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_alu_result !== 32'hA || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold rdy=%b alu=%h v=%b exp 0/a/1",
               in_ready, out_alu_result, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_alu_result !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_B alu=%h v=%b rdy=%b exp b/1/1",
               out_alu_result, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_alu_result !== 32'hC || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_C alu=%h v=%b exp c/1", out_alu_result, out_valid);
    end
    drive(1'b0, 32'h0, 6'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h1A, 6'b000010, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h1B, 6'b000010, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_pre rdy=%b exp 0", in_ready);
    end
    drive(1'b1, 32'h1D, 6'b000010, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill v=%b ctrl=%b rdy=%b exp 0/0/1",
               out_valid, out_ctrl, in_ready);
    end
    drive(1'b0, 32'h0, 6'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak cyc=%0d v=%b alu=%h exp v=0",
                 i, out_valid, out_alu_result);
      end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b0, 32'h55, 6'b000010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 6'b0) begin
        errors++;
        $display("FAIL bubble cyc=%0d v=%b ctrl=%b exp 0/0",
                 i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h2A, 6'b011010, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h2B, 6'b011010, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 6'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid v=%b ctrl=%b rdy=%b exp 0/0/1",
               out_valid, out_ctrl, in_ready);
    end
    checks++;
    if (out_alu_result !== 32'h0 || out_dest_reg !== 5'h0) begin
      errors++;
      $display("FAIL rst_mid_data alu=%h rd=%h exp 0/0",
               out_alu_result, out_dest_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after v=%b exp 0", out_valid);
    end
  endtask

`ifdef EXMEM_BRANCH_RESOLVE_EN
  task automatic test_taken();
    out_ready = 1'b1;
    drive(1'b1, 32'h30, 6'b000001, 1'b1);
    @(negedge clk);
    checks++;
    if (out_taken !== 1'b1) begin
      errors++; $display("FAIL taken_beq got=%b exp 1", out_taken);
    end
    drive(1'b1, 32'h31, 6'b100000, 1'b0);
    @(negedge clk);
    checks++;
    if (out_taken !== 1'b1) begin
      errors++; $display("FAIL taken_jump got=%b exp 1", out_taken);
    end
    drive(1'b1, 32'h32, 6'b000001, 1'b0);
    @(negedge clk);
    checks++;
    if (out_taken !== 1'b0) begin
      errors++; $display("FAIL taken_nz got=%b exp 0", out_taken);
    end
    drive(1'b0, 32'h0, 6'b100000, 1'b1);
    @(negedge clk);
    checks++;
    if (out_taken !== 1'b0) begin
      errors++; $display("FAIL taken_bubble got=%b exp 0", out_taken);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_back_to_back();
    test_flush();
    test_bubble();
    test_reset_mid();
`ifdef EXMEM_BRANCH_RESOLVE_EN
    test_taken();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
